erode_3x3: RTL

ERODE_3X3 -- requirements
Module: erode_3x3

---
 rtl/erode_3x3.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/erode_3x3.sv
// Binary 3x3 erosion over a raster stream; out(k) is valid one cycle after step k+WIDTH+1.
// The upstream source stalls on Busy, which is high during the WIDTH+1 cycle end-of-frame flush. Value gaps stall everything.
module erode_3x3 #(
  parameter int   WIDTH  = 640,
  parameter int   HEIGHT = 480,
  parameter logic BORDER = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic Value,
  input  logic Sof,
  input  logic Data_in,
  output logic Data_out,
  output logic Out_valid,
  output logic Out_sof,
  output logic Busy,
  output logic Err
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = $clog2(HEIGHT + 2);
  localparam int OW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST    = CW'(WIDTH - 1);
  localparam logic [RW-1:0] IN_ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [OW-1:0] ROW_LAST    = OW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   in_col, out_col;
  logic [RW-1:0]   in_row;
  logic [OW-1:0]   out_row;
  logic [WIDTH-1:0] lb0, lb1;
  logic [2:0]      tap [3];
  logic [2:0]      win [3];
  logic            step, restart, err_set, pix;
  logic            produce, last_in, last_out, window_and;

  assign last_in  = (in_row == IN_ROW_LAST) && (in_col == COL_LAST);
  assign last_out = (out_row == ROW_LAST) && (out_col == COL_LAST);
  // The first output needs step WIDTH+1, i.e. input position (1,1) or later.
  assign produce  = !restart && ((in_row > RW'(1)) || ((in_row == RW'(1)) && (in_col != '0)));
  assign Busy     = (state_q == FLUSH);

  always_comb begin
    state_d = state_q;
    step    = 1'b0;
    restart = 1'b0;
    err_set = 1'b0;
    pix     = BORDER;
    case (state_q)
      IDLE: begin
        if (Value) begin
          if (Sof) begin
            step    = 1'b1;
            restart = 1'b1;
            pix     = Data_in;
            state_d = RUN;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      RUN: begin
        if (Value) begin
          step = 1'b1;
          pix  = Data_in;
          if (Sof) begin
            restart = 1'b1;
            err_set = 1'b1;
          end else if (last_in) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        step    = 1'b1;
        err_set = Value;
        if (last_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Window columns: 0 = oldest, 2 = the column entering on this step.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win[r][0] = tap[r][1];
      win[r][1] = tap[r][2];
    end
    win[0][2] = lb1[WIDTH-1];
    win[1][2] = lb0[WIDTH-1];
    win[2][2] = pix;
  end

  // Edge taps come from counters only, so stale line-buffer data never leaks in.
  always_comb begin
    window_and = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if ((r == 0 && out_row == '0) || (r == 2 && out_row == ROW_LAST) ||
            (c == 0 && out_col == '0) || (c == 2 && out_col == COL_LAST))
          window_and = window_and & BORDER;
        else
          window_and = window_and & win[r][c];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (step) begin
      lb0 <= {lb0[WIDTH-2:0], pix};
      lb1 <= {lb1[WIDTH-2:0], lb0[WIDTH-1]};
      for (int r = 0; r < 3; r++) tap[r] <= win[r];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      in_col    <= '0;
      in_row    <= '0;
      out_col   <= '0;
      out_row   <= '0;
      Data_out  <= 1'b0;
      Out_valid <= 1'b0;
      Out_sof   <= 1'b0;
      Err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      Err       <= Err | err_set;
      Out_valid <= step && produce;
      Out_sof   <= step && produce && (out_col == '0) && (out_row == '0);
      if (step && produce) Data_out <= window_and;
      if (step) begin
        if (restart) begin
          in_col  <= CW'(1);
          in_row  <= '0;
          out_col <= '0;
          out_row <= '0;
        end else begin
          if (in_col == COL_LAST) begin
            in_col <= '0;
            in_row <= in_row + 1'b1;
          end else begin
            in_col <= in_col + 1'b1;
          end
          if (produce) begin
            if (out_col == COL_LAST) begin
              out_col <= '0;
              out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
            end else begin
              out_col <= out_col + 1'b1;
            end
          end
        end
      end
    end
  end
endmodule
